// File: rtl/score_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// score_cmd_seq_if
//   Bundles the keypad inputs and scoreboard outputs of score_cmd_seq.
//   master : keypad / enable driver side (drives en_score, key_row, key_column)
//   slave  : the sequencer (drives score, team_armed, upd, upd_team, upd_pts)
//   Signals:
//     en_score   1  scoring enable
//     key_row    4  one-hot keypad row, 0 = no key
//     key_column 4  one-hot keypad column, 0 = no key
//     score      16 {A_tens,A_ones,B_tens,B_ones} BCD
//     team_armed 2  01 = A armed, 10 = B armed, 00 = idle
//     upd        1  one-cycle pulse on every score change
//     upd_team   1  team of last change (0 = A, 1 = B)
//     upd_pts    2  points applied/removed by last change
// ---------------------------------------------------------------------------
interface score_cmd_seq_if;
  logic        en_score;
  logic [3:0]  key_row;
  logic [3:0]  key_column;
  logic [15:0] score;
  logic [1:0]  team_armed;
  logic        upd;
  logic        upd_team;
  logic [1:0]  upd_pts;

  modport master (
    output en_score, key_row, key_column,
    input  score, team_armed, upd, upd_team, upd_pts
  );

  modport slave (
    input  en_score, key_row, key_column,
    output score, team_armed, upd, upd_team, upd_pts
  );
endinterface

// File: rtl/score_cmd_seq.sv
// ---------------------------------------------------------------------------
// score_cmd_seq
//   Keypad command sequencer and score-register owner for the basketball
//   scoreboard. Debounces the 4x4 keypad, decodes two-stroke commands
//   (team select, then point value) and applies saturating 2-digit BCD
//   additions to the two team scores.
//
//   Ports:
//     clk_in  in  system clock, rising edge
//     rst     in  synchronous active-high reset
//     bus     slave modport of score_cmd_seq_if (keys, enable, score outputs)
//
//   Parameters:
//     DEB_CYCLES  clocks a raw key code must be stable to be accepted
//     TMO_CYCLES  clocks an armed team waits for a point key
//
//   Optional feature macro: SCORE_UNDO_EN
//     When defined, a single-entry history of the last commit is kept and
//     the UNDO key (row 0001, column 1000) reverses it from IDLE.
// ---------------------------------------------------------------------------
module score_cmd_seq #(
  parameter int DEB_CYCLES = 16,
  parameter int TMO_CYCLES = 4096
) (
  input  logic           clk_in,
  input  logic           rst,
  score_cmd_seq_if.slave bus
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TMO_W = $clog2(TMO_CYCLES);

  // Key codes are {row, column}
  localparam logic [7:0] CODE_NONE   = 8'b0000_0000;
  localparam logic [7:0] CODE_TEAM_A = 8'b1000_0001;
  localparam logic [7:0] CODE_TEAM_B = 8'b1000_0100;
  localparam logic [7:0] CODE_PTS1   = 8'b0001_0001;
  localparam logic [7:0] CODE_PTS2   = 8'b0001_0010;
  localparam logic [7:0] CODE_PTS3   = 8'b0001_0100;
`ifdef SCORE_UNDO_EN
  localparam logic [7:0] CODE_UNDO   = 8'b0001_1000;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM_A = 2'd1;
  localparam logic [1:0] ST_ARM_B = 2'd2;

  localparam logic [2:0] KEY_NONE   = 3'd0;
  localparam logic [2:0] KEY_TEAM_A = 3'd1;
  localparam logic [2:0] KEY_TEAM_B = 3'd2;
  localparam logic [2:0] KEY_PTS    = 3'd3;
`ifdef SCORE_UNDO_EN
  localparam logic [2:0] KEY_UNDO   = 3'd4;
`endif

  // ---------------------------------------------------------------------
  // BCD helpers
  // ---------------------------------------------------------------------
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    bcd_to_bin = (7'(bcd[7:4]) * 7'd10) + 7'(bcd[3:0]);
  endfunction

  // Adds at most 3; caller guarantees the result stays <= 99
  function automatic logic [7:0] bcd_add(input logic [7:0] bcd, input logic [1:0] n);
    logic [4:0] ones;
    ones = {1'b0, bcd[3:0]} + {3'b000, n};
    if (ones > 5'd9) begin
      bcd_add = {bcd[7:4] + 4'd1, 4'(ones - 5'd10)};
    end else begin
      bcd_add = {bcd[7:4], ones[3:0]};
    end
  endfunction

`ifdef SCORE_UNDO_EN
  // Subtracts at most 3; caller guarantees the result stays >= 0
  function automatic logic [7:0] bcd_sub(input logic [7:0] bcd, input logic [1:0] n);
    if (bcd[3:0] >= {2'b00, n}) begin
      bcd_sub = {bcd[7:4], bcd[3:0] - {2'b00, n}};
    end else begin
      bcd_sub = {bcd[7:4] - 4'd1, bcd[3:0] + 4'd10 - {2'b00, n}};
    end
  endfunction
`endif

  // min(limit, n): used both for saturation headroom and the undo floor
  function automatic logic [1:0] clamp_pts(input logic [6:0] limit, input logic [1:0] n);
    if (limit < {5'b00000, n}) begin
      clamp_pts = limit[1:0];
    end else begin
      clamp_pts = n;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Raw code and debounce
  // ---------------------------------------------------------------------
  logic             raw_valid_s;
  logic [7:0]       raw_code_s;
  logic [7:0]       raw_last_r;
  logic [7:0]       deb_code_r;
  logic [DEB_W-1:0] stable_cnt_r;
  logic             press_r;

  // Raw keypad code: exactly one row and one column bit, otherwise NONE
  always_comb begin
    raw_valid_s = $onehot(bus.key_row) && $onehot(bus.key_column);
    if (raw_valid_s) begin
      raw_code_s = {bus.key_row, bus.key_column};
    end else begin
      raw_code_s = CODE_NONE;
    end
  end

  // Debounce: stable_cnt_r counts consecutive clocks the raw code was seen;
  // it saturates at DEB_CYCLES so a held key is accepted only once.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      raw_last_r   <= CODE_NONE;
      deb_code_r   <= CODE_NONE;
      stable_cnt_r <= DEB_W'(0);
      press_r      <= 1'b0;
    end else if (raw_code_s != raw_last_r) begin
      raw_last_r   <= raw_code_s;
      stable_cnt_r <= DEB_W'(1);
      press_r      <= 1'b0;
    end else if (stable_cnt_r == DEB_W'(DEB_CYCLES - 1)) begin
      stable_cnt_r <= DEB_W'(DEB_CYCLES);
      deb_code_r   <= raw_last_r;
      press_r      <= (raw_last_r != deb_code_r) && (raw_last_r != CODE_NONE);
    end else if (stable_cnt_r < DEB_W'(DEB_CYCLES - 1)) begin
      stable_cnt_r <= stable_cnt_r + DEB_W'(1);
      press_r      <= 1'b0;
    end else begin
      press_r      <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Key decode
  // ---------------------------------------------------------------------
  logic [2:0] key_s;
  logic [1:0] key_pts_s;

  // Classify the press event; unmapped codes decode to KEY_NONE
  always_comb begin
    key_s     = KEY_NONE;
    key_pts_s = 2'd0;
    if (press_r) begin
      case (deb_code_r)
        CODE_TEAM_A: key_s = KEY_TEAM_A;
        CODE_TEAM_B: key_s = KEY_TEAM_B;
        CODE_PTS1: begin key_s = KEY_PTS; key_pts_s = 2'd1; end
        CODE_PTS2: begin key_s = KEY_PTS; key_pts_s = 2'd2; end
        CODE_PTS3: begin key_s = KEY_PTS; key_pts_s = 2'd3; end
`ifdef SCORE_UNDO_EN
        CODE_UNDO: key_s = KEY_UNDO;
`endif
        default:   key_s = KEY_NONE;
      endcase
    end else begin
      key_s = KEY_NONE;
    end
  end

  // ---------------------------------------------------------------------
  // Command FSM and score datapath
  // ---------------------------------------------------------------------
  logic [1:0]       state_r, state_nxt_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_nxt_s;
  logic [7:0]       score_a_r, score_a_nxt_s;
  logic [7:0]       score_b_r, score_b_nxt_s;
  logic             upd_r, upd_nxt_s;
  logic             upd_team_r, upd_team_nxt_s;
  logic [1:0]       upd_pts_r, upd_pts_nxt_s;
  logic [1:0]       team_armed_r, team_armed_s;
  logic             arm_team_s;
  logic [7:0]       team_score_s;
  logic [1:0]       add_pts_s;
`ifdef SCORE_UNDO_EN
  logic             hist_valid_r, hist_valid_nxt_s;
  logic             hist_team_r, hist_team_nxt_s;
  logic [1:0]       hist_pts_r, hist_pts_nxt_s;
  logic [7:0]       undo_score_s;
  logic [1:0]       sub_pts_s;
`endif

  // Next-state, timeout and score update logic
  always_comb begin
    state_nxt_s    = state_r;
    tmo_nxt_s      = tmo_cnt_r;
    score_a_nxt_s  = score_a_r;
    score_b_nxt_s  = score_b_r;
    upd_nxt_s      = 1'b0;
    upd_team_nxt_s = upd_team_r;
    upd_pts_nxt_s  = upd_pts_r;
    arm_team_s     = (state_r == ST_ARM_B);
    if (arm_team_s) begin
      team_score_s = score_b_r;
    end else begin
      team_score_s = score_a_r;
    end
    // Amount that fits below 99 for the armed team
    add_pts_s = clamp_pts(7'd99 - bcd_to_bin(team_score_s), key_pts_s);
`ifdef SCORE_UNDO_EN
    hist_valid_nxt_s = hist_valid_r;
    hist_team_nxt_s  = hist_team_r;
    hist_pts_nxt_s   = hist_pts_r;
    if (hist_team_r) begin
      undo_score_s = score_b_r;
    end else begin
      undo_score_s = score_a_r;
    end
    sub_pts_s = clamp_pts(bcd_to_bin(undo_score_s), hist_pts_r);
`endif

    if (!bus.en_score) begin
      state_nxt_s = ST_IDLE;
      tmo_nxt_s   = TMO_W'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          tmo_nxt_s = TMO_W'(0);
          if (key_s == KEY_TEAM_A) begin
            state_nxt_s = ST_ARM_A;
          end else if (key_s == KEY_TEAM_B) begin
            state_nxt_s = ST_ARM_B;
`ifdef SCORE_UNDO_EN
          end else if ((key_s == KEY_UNDO) && hist_valid_r) begin
            if (sub_pts_s != 2'd0) begin
              if (hist_team_r) begin
                score_b_nxt_s = bcd_sub(score_b_r, sub_pts_s);
              end else begin
                score_a_nxt_s = bcd_sub(score_a_r, sub_pts_s);
              end
              upd_nxt_s      = 1'b1;
              upd_team_nxt_s = hist_team_r;
              upd_pts_nxt_s  = sub_pts_s;
            end else begin
              upd_nxt_s = 1'b0;
            end
            hist_valid_nxt_s = 1'b0;
`endif
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ARM_A, ST_ARM_B: begin
          if (key_s == KEY_TEAM_A) begin
            state_nxt_s = ST_ARM_A;
            tmo_nxt_s   = TMO_W'(0);
          end else if (key_s == KEY_TEAM_B) begin
            state_nxt_s = ST_ARM_B;
            tmo_nxt_s   = TMO_W'(0);
          end else if (key_s == KEY_PTS) begin
            state_nxt_s   = ST_IDLE;
            tmo_nxt_s     = TMO_W'(0);
            upd_pts_nxt_s = add_pts_s;
            // A team already at 99 gets nothing: no pulse, no history entry
            if (add_pts_s != 2'd0) begin
              if (arm_team_s) begin
                score_b_nxt_s = bcd_add(score_b_r, add_pts_s);
              end else begin
                score_a_nxt_s = bcd_add(score_a_r, add_pts_s);
              end
              upd_nxt_s      = 1'b1;
              upd_team_nxt_s = arm_team_s;
`ifdef SCORE_UNDO_EN
              hist_valid_nxt_s = 1'b1;
              hist_team_nxt_s  = arm_team_s;
              hist_pts_nxt_s   = add_pts_s;
`endif
            end else begin
              upd_nxt_s = 1'b0;
            end
`ifdef SCORE_UNDO_EN
          end else if (key_s == KEY_UNDO) begin
            state_nxt_s = ST_IDLE;
            tmo_nxt_s   = TMO_W'(0);
`endif
          end else if (tmo_cnt_r == TMO_W'(TMO_CYCLES - 1)) begin
            state_nxt_s = ST_IDLE;
            tmo_nxt_s   = TMO_W'(0);
          end else begin
            tmo_nxt_s = tmo_cnt_r + TMO_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          tmo_nxt_s   = TMO_W'(0);
        end
      endcase
    end
  end

  // Armed-team indication derived from the current state
  always_comb begin
    case (state_r)
      ST_ARM_A: team_armed_s = 2'b01;
      ST_ARM_B: team_armed_s = 2'b10;
      default:  team_armed_s = 2'b00;
    endcase
  end

  // FSM, score and update-report registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      tmo_cnt_r    <= TMO_W'(0);
      score_a_r    <= 8'h00;
      score_b_r    <= 8'h00;
      upd_r        <= 1'b0;
      upd_team_r   <= 1'b0;
      upd_pts_r    <= 2'd0;
      team_armed_r <= 2'b00;
    end else begin
      state_r      <= state_nxt_s;
      tmo_cnt_r    <= tmo_nxt_s;
      score_a_r    <= score_a_nxt_s;
      score_b_r    <= score_b_nxt_s;
      upd_r        <= upd_nxt_s;
      upd_team_r   <= upd_team_nxt_s;
      upd_pts_r    <= upd_pts_nxt_s;
      team_armed_r <= team_armed_s;
    end
  end

`ifdef SCORE_UNDO_EN
  // Single-entry commit history for UNDO
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hist_valid_r <= 1'b0;
      hist_team_r  <= 1'b0;
      hist_pts_r   <= 2'd0;
    end else begin
      hist_valid_r <= hist_valid_nxt_s;
      hist_team_r  <= hist_team_nxt_s;
      hist_pts_r   <= hist_pts_nxt_s;
    end
  end
`endif

  assign bus.score      = {score_a_r, score_b_r};
  assign bus.team_armed = team_armed_r;
  assign bus.upd        = upd_r;
  assign bus.upd_team   = upd_team_r;
  assign bus.upd_pts    = upd_pts_r;

endmodule

// File: tb/tb_score_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_score_cmd_seq
//   Directed scenarios followed by randomized key sequences, checked against
//   a behavioural model of the scoreboard (integer scores, armed team,
//   one-entry history) and a queue of expected update reports.
// ---------------------------------------------------------------------------
module tb_score_cmd_seq;
  localparam int DEB = 16;
  localparam int TMO = 4096;

  // Key indices into the tables below
  localparam int K_TEAM_A = 0;
  localparam int K_TEAM_B = 1;
  localparam int K_PTS1   = 2;
  localparam int K_PTS2   = 3;
  localparam int K_PTS3   = 4;
  localparam int K_UNDO   = 5;
  localparam int K_OTHER  = 6;  // valid code with no function
  localparam int K_BAD    = 7;  // two rows pressed: not a valid code

  logic clk = 1'b0;
  logic rst;
  score_cmd_seq_if bus ();

  score_cmd_seq #(.DEB_CYCLES(DEB), .TMO_CYCLES(TMO)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] row_tab [8];
  logic [3:0] col_tab [8];

  int checks = 0;
  int fails  = 0;

  // Reference model state
  int ma, mb, armed;
  bit m_en;
  bit hist_v;
  int hist_t, hist_p;
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];

  // Record every update pulse as {team, pts}
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.upd === 1'b1) obs_q.push_back({bus.upd_team, bus.upd_pts});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_score();
    return {4'(ma / 10), 4'(ma % 10), 4'(mb / 10), 4'(mb % 10)};
  endfunction

  function automatic logic [1:0] m_armed();
    return (armed == 1) ? 2'b01 : (armed == 2) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0; armed = 0; hist_v = 1'b0; hist_t = 0; hist_p = 0;
  endtask

  // Effect of one accepted key press on the model
  task automatic model_key(input int k);
    int n, cur, app;
    if (!m_en) return;
    case (k)
      K_TEAM_A: armed = 1;
      K_TEAM_B: armed = 2;
      K_PTS1, K_PTS2, K_PTS3: begin
        if (armed != 0) begin
          n   = k - K_PTS1 + 1;
          cur = (armed == 2) ? mb : ma;
          app = (99 - cur < n) ? 99 - cur : n;
          if (app > 0) begin
            if (armed == 2) mb += app; else ma += app;
            exp_q.push_back({(armed == 2) ? 1'b1 : 1'b0, 2'(app)});
            hist_v = 1'b1; hist_t = armed - 1; hist_p = app;
          end
          armed = 0;
        end
      end
`ifdef SCORE_UNDO_EN
      K_UNDO: begin
        if (armed != 0) begin
          armed = 0;
        end else if (hist_v) begin
          cur = (hist_t != 0) ? mb : ma;
          app = (cur < hist_p) ? cur : hist_p;
          if (hist_t != 0) mb -= app; else ma -= app;
          if (app > 0) exp_q.push_back({(hist_t != 0) ? 1'b1 : 1'b0, 2'(app)});
          hist_v = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  endtask

  // Press key k for 'hold' clocks, then release for 'rel' clocks
  task automatic do_key(input int k, input int hold, input int rel);
    bus.key_row    = row_tab[k];
    bus.key_column = col_tab[k];
    tick(hold);
    model_key(k);
    if (rel > 0) begin
      bus.key_row    = 4'b0000;
      bus.key_column = 4'b0000;
      tick(rel);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " score"}, 32'(bus.score), 32'(m_score()));
    chk({tag, " team_armed"}, 32'(bus.team_armed), 32'(m_armed()));
  endtask

  task automatic check_upd(input string tag);
    chk({tag, " upd count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, " upd team/pts"}, 32'(obs_q[i]), 32'(exp_q[i]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int k, hold, rel, prev_k;
    bit prev_norel;

    row_tab = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1100};
    col_tab = '{4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};

    // Reset
    rst = 1'b1; bus.en_score = 1'b0; bus.key_row = 4'b0000; bus.key_column = 4'b0000;
    model_reset(); m_en = 1'b0;
    tick(4);
    rst = 1'b0;
    bus.en_score = 1'b1; m_en = 1'b1;
    tick(1);
    chk("reset score", 32'(bus.score), 32'h0000);
    chk("reset team_armed", 32'(bus.team_armed), 32'h0);
    chk("reset upd", 32'(bus.upd), 32'h0);
    chk("reset upd_team", 32'(bus.upd_team), 32'h0);
    chk("reset upd_pts", 32'(bus.upd_pts), 32'h0);

    // Team A: 1 + 2 + 3
    do_key(K_TEAM_A, 36, 20);
    check_state("arm A");
    do_key(K_PTS1, 24, 20);
    do_key(K_TEAM_A, 24, 20); do_key(K_PTS2, 24, 20);
    do_key(K_TEAM_A, 24, 20); do_key(K_PTS3, 24, 20);
    check_state("team A 6");
    chk("team A 6 literal", 32'(bus.score), 32'h0600);
    check_upd("team A 6");

    // Team B: 1 + 2 + 3
    do_key(K_TEAM_B, 24, 20); do_key(K_PTS1, 24, 20);
    do_key(K_TEAM_B, 24, 20); do_key(K_PTS2, 24, 20);
    do_key(K_TEAM_B, 24, 20); do_key(K_PTS3, 24, 20);
    check_state("team B 6");
    chk("team B 6 literal", 32'(bus.score), 32'h0606);
    check_upd("team B 6");

    // Scoring disabled
    bus.en_score = 1'b0; m_en = 1'b0; armed = 0;
    do_key(K_TEAM_B, 24, 20); do_key(K_PTS2, 24, 20);
    check_state("disabled");
    check_upd("disabled");
    bus.en_score = 1'b1; m_en = 1'b1;
    tick(2);

    // Drive team A up to 98, then saturate
    while (ma <= 95) begin
      do_key(K_TEAM_A, 20, 18); do_key(K_PTS3, 20, 18);
    end
    do_key(K_TEAM_A, 20, 18); do_key(K_PTS1 + (98 - ma) - 1, 20, 18);
    check_state("A at 98");
    check_upd("A to 98");
    do_key(K_TEAM_A, 20, 18); do_key(K_PTS3, 20, 18);
    chk("saturate A tens/ones", 32'(bus.score[15:8]), 32'h99);
    check_state("saturate");
    check_upd("saturate");
    do_key(K_TEAM_A, 20, 18); do_key(K_PTS3, 20, 18);
    check_state("at 99 again");
    check_upd("at 99 again");

    // Arm timeout
    do_key(K_TEAM_A, 30, 20);
    tick(TMO - 100);
    check_state("before timeout");
    tick(200);
    armed = 0;
    chk("timeout team_armed", 32'(bus.team_armed), 32'h0);
    do_key(K_PTS2, 24, 20);
    check_state("after timeout");
    check_upd("after timeout");

    // Short glitch must not be taken as a press
    do_key(K_TEAM_B, 24, 20);
    bus.key_row = row_tab[K_PTS2]; bus.key_column = col_tab[K_PTS2];
    tick(10);
    bus.key_row = 4'b0000; bus.key_column = 4'b0000;
    tick(30);
    check_state("glitch");
    check_upd("glitch");
    do_key(K_PTS2, 24, 20);
    check_state("after glitch");
    check_upd("after glitch");

    // Reset while armed
    do_key(K_TEAM_B, 24, 20);
    check_state("arm B pre-reset");
    rst = 1'b1; tick(1); rst = 1'b0;
    model_reset();
    tick(1);
    chk("mid-arm reset team_armed", 32'(bus.team_armed), 32'h0);
    chk("mid-arm reset score", 32'(bus.score), 32'h0000);
    check_upd("mid-arm reset");

`ifdef SCORE_UNDO_EN
    do_key(K_TEAM_A, 24, 20); do_key(K_PTS3, 24, 20);
    do_key(K_UNDO, 24, 20);
    chk("undo score", 32'(bus.score), 32'h0000);
    check_state("undo");
    check_upd("undo");
    do_key(K_UNDO, 24, 20);
    check_state("second undo");
    check_upd("second undo");
    do_key(K_TEAM_B, 24, 20); do_key(K_PTS2, 24, 20);
    do_key(K_TEAM_A, 24, 20); do_key(K_UNDO, 24, 20);
    check_state("undo while armed");
    check_upd("undo while armed");
`endif

    // Randomized key sequences
    prev_k = -1; prev_norel = 1'b0;
    for (int step = 0; step < 80; step++) begin
      if (!prev_norel && $urandom_range(0, 9) == 0) begin
        bus.en_score = ~bus.en_score;
        m_en = bus.en_score;
        if (!m_en) armed = 0;
        tick(3);
      end
      k = $urandom_range(0, 7);
      if (prev_norel && k == prev_k) k = (k + 1) % 8;
      hold = $urandom_range(22, 30);
      rel  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(18, 30);
      do_key(k, hold, rel);
      check_state("random");
      check_upd("random");
      prev_k = k;
      prev_norel = (rel == 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
